// File: rtl/ctrl_pkg.sv
// Shared constants and the decoded control bundle for the pipelined control unit.
package ctrl_pkg;

  // Opcodes with the top bit set; anything from OP_RSV_LO upward is reserved.
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_BEQ    = 4'b1010;
  localparam logic [3:0] OP_RSV_LO = 4'b1011;

  // ALU operations used by the memory and branch instructions.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Operand source selects for the EX stage.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Decoded control bundle; the ALU op travels alongside because its width is a parameter.
  typedef struct packed {
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic reg_dst;
    logic branch;
    logic reads_rt;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{default: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-side inputs and pipeline control outputs of pipe_ctrl, bundled for port hookup.
interface pipe_ctrl_if #(
  parameter int OPW  = 4,
  parameter int RAW  = 4,
  parameter int ALUW = 3
);
  logic            id_valid;
  logic [OPW-1:0]  id_op;
  logic [RAW-1:0]  id_rs;
  logic [RAW-1:0]  id_rt;
  logic [RAW-1:0]  id_rd;
  logic            ex_zero;
  logic            stall;
  logic            flush;
  logic            id_reg_dst;
  logic [ALUW-1:0] ex_aluop;
  logic            ex_alu_src;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            mem_read;
  logic            mem_write;
  logic            wb_write_en;
  logic            wb_mem_to_reg;
  logic [RAW-1:0]  wb_waddr;

  // Datapath / IF side: drives the ID fields, consumes the controls.
  modport master (
    output id_valid, id_op, id_rs, id_rt, id_rd, ex_zero,
    input  stall, flush, id_reg_dst, ex_aluop, ex_alu_src, fwd_a, fwd_b,
           mem_read, mem_write, wb_write_en, wb_mem_to_reg, wb_waddr
  );

  // Control unit side.
  modport slave (
    input  id_valid, id_op, id_rs, id_rt, id_rd, ex_zero,
    output stall, flush, id_reg_dst, ex_aluop, ex_alu_src, fwd_a, fwd_b,
           mem_read, mem_write, wb_write_en, wb_mem_to_reg, wb_waddr
  );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder: opcode plus valid -> control bundle and ALU op.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic            valid,
  input  logic [OPW-1:0]  op,
  output ctrl_t           ctrl,
  output logic [ALUW-1:0] aluop
);

  // Map the opcode onto control flags; invalid or reserved slots become a NOP.
  always_comb begin
    ctrl  = CTRL_NOP;
    aluop = {ALUW{1'b0}};
    if (!valid) begin
      ctrl = CTRL_NOP;
    end else if (op[OPW-1] == 1'b0) begin
      aluop           = ALUW'(op[2:0]);
      ctrl.reg_write  = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.reads_rt   = 1'b1;
    end else if (op[OPW-1 -: 4] >= OP_RSV_LO) begin
      ctrl = CTRL_NOP;
    end else begin
      case (op[OPW-1 -: 4])
        OP_LW: begin
          aluop          = ALUW'(ALU_ADD);
          ctrl.alu_src   = 1'b1;
          ctrl.mem_read  = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        OP_SW: begin
          aluop          = ALUW'(ALU_ADD);
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
          ctrl.reads_rt  = 1'b1;
        end
        OP_BEQ: begin
          aluop         = ALUW'(ALU_SUB);
          ctrl.reg_dst  = 1'b1;
          ctrl.branch   = 1'b1;
          ctrl.reads_rt = 1'b1;
        end
        default: ctrl = CTRL_NOP;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use stall, branch flush and EX-stage forwarding selects.
module pipe_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int RAW  = 4,
  parameter int ALUW = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [RAW-1:0] REG_ZERO = {RAW{1'b0}};

  ctrl_t           dec;
  logic [ALUW-1:0] dec_aluop;
  logic            dec_write;
  logic [RAW-1:0]  dec_waddr;

  logic            load_use;
  logic            branch_taken;
  logic            bubble;
  logic            em_fwd_ok;
  logic            mw_fwd_ok;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;

  // ID/EX stage
  logic            idex_valid;
  logic [ALUW-1:0] idex_aluop;
  logic            idex_alu_src;
  logic            idex_mem_read;
  logic            idex_mem_write;
  logic            idex_reg_write;
  logic            idex_mem_to_reg;
  logic            idex_branch;
  logic [RAW-1:0]  idex_rs;
  logic [RAW-1:0]  idex_rt;
  logic [RAW-1:0]  idex_waddr;

  // EX/MEM stage
  logic            exmem_valid;
  logic            exmem_mem_read;
  logic            exmem_mem_write;
  logic            exmem_reg_write;
  logic            exmem_mem_to_reg;
  logic [RAW-1:0]  exmem_waddr;

  // MEM/WB stage
  logic            memwb_valid;
  logic            memwb_reg_write;
  logic            memwb_mem_to_reg;
  logic [RAW-1:0]  memwb_waddr;

  ctrl_decode #(
    .OPW  (OPW),
    .ALUW (ALUW)
  ) u_decode (
    .valid (bus.id_valid),
    .op    (bus.id_op),
    .ctrl  (dec),
    .aluop (dec_aluop)
  );

  // Suppress writes to the hardwired-zero register right at decode.
  always_comb begin
    dec_write = dec.reg_write && (bus.id_rd != REG_ZERO);
    if (dec_write) begin
      dec_waddr = bus.id_rd;
    end else begin
      dec_waddr = REG_ZERO;
    end
  end

  // Load-use: a load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = 1'b0;
    if (idex_valid && idex_mem_read && (idex_waddr != REG_ZERO)) begin
      load_use = (idex_waddr == bus.id_rs) ||
                 (dec.reads_rt && (idex_waddr == bus.id_rt));
    end else begin
      load_use = 1'b0;
    end
  end

  assign branch_taken = idex_valid & idex_branch & bus.ex_zero;
  assign bubble       = load_use | branch_taken;

  // Loads in EX/MEM never forward: their data is not ready until MEM/WB.
  assign em_fwd_ok = exmem_valid && exmem_reg_write && !exmem_mem_read &&
                     (exmem_waddr != REG_ZERO);
  assign mw_fwd_ok = memwb_valid && memwb_reg_write && (memwb_waddr != REG_ZERO);

  // Operand source selects; the younger EX/MEM result takes precedence.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (em_fwd_ok && (exmem_waddr == idex_rs)) begin
      fwd_a = FWD_EXMEM;
    end else if (mw_fwd_ok && (memwb_waddr == idex_rs)) begin
      fwd_a = FWD_MEMWB;
    end else begin
      fwd_a = FWD_RF;
    end
    if (em_fwd_ok && (exmem_waddr == idex_rt)) begin
      fwd_b = FWD_EXMEM;
    end else if (mw_fwd_ok && (memwb_waddr == idex_rt)) begin
      fwd_b = FWD_MEMWB;
    end else begin
      fwd_b = FWD_RF;
    end
  end

  // ID/EX register: load the decoded instruction, or a bubble on stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid      <= 1'b0;
      idex_aluop      <= {ALUW{1'b0}};
      idex_alu_src    <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_reg_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_branch     <= 1'b0;
      idex_rs         <= REG_ZERO;
      idex_rt         <= REG_ZERO;
      idex_waddr      <= REG_ZERO;
    end else if (bubble) begin
      idex_valid      <= 1'b0;
      idex_aluop      <= {ALUW{1'b0}};
      idex_alu_src    <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_reg_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_branch     <= 1'b0;
      idex_rs         <= REG_ZERO;
      idex_rt         <= REG_ZERO;
      idex_waddr      <= REG_ZERO;
    end else begin
      idex_valid      <= bus.id_valid;
      idex_aluop      <= dec_aluop;
      idex_alu_src    <= dec.alu_src;
      idex_mem_read   <= dec.mem_read;
      idex_mem_write  <= dec.mem_write;
      idex_reg_write  <= dec_write;
      idex_mem_to_reg <= dec.mem_to_reg;
      idex_branch     <= dec.branch;
      idex_rs         <= bus.id_rs;
      idex_rt         <= bus.id_rt;
      idex_waddr      <= dec_waddr;
    end
  end

  // EX/MEM register: always advances, even while ID is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_valid      <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_waddr      <= REG_ZERO;
    end else begin
      exmem_valid      <= idex_valid;
      exmem_mem_read   <= idex_mem_read;
      exmem_mem_write  <= idex_mem_write;
      exmem_reg_write  <= idex_reg_write;
      exmem_mem_to_reg <= idex_mem_to_reg;
      exmem_waddr      <= idex_waddr;
    end
  end

  // MEM/WB register: always advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_valid      <= 1'b0;
      memwb_reg_write  <= 1'b0;
      memwb_mem_to_reg <= 1'b0;
      memwb_waddr      <= REG_ZERO;
    end else begin
      memwb_valid      <= exmem_valid;
      memwb_reg_write  <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
      memwb_waddr      <= exmem_waddr;
    end
  end

  // Flush outranks stall: the stalled ID instruction is discarded anyway.
  assign bus.stall         = load_use & ~branch_taken;
  assign bus.flush         = branch_taken;
  assign bus.id_reg_dst    = dec.reg_dst;
  assign bus.fwd_a         = fwd_a;
  assign bus.fwd_b         = fwd_b;
  assign bus.ex_aluop      = idex_aluop;
  assign bus.ex_alu_src    = idex_alu_src;
  assign bus.mem_read      = exmem_mem_read;
  assign bus.mem_write     = exmem_mem_write;
  assign bus.wb_write_en   = memwb_reg_write;
  assign bus.wb_mem_to_reg = memwb_mem_to_reg;
  assign bus.wb_waddr      = memwb_waddr;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined control unit for the 4-stage datapath (ID→EX→MEM→WB). It decodes the opcode in ID, carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages, and generates load-use stall, branch flush and EX-stage forwarding selects. The combinational decoder alone cannot provide this behaviour. The unit sits between the IF/ID register and the datapath, and is generalised in opcode, register-address and ALU-op widths.

## Interface
- OPW, 4, opcode width
- RAW, 4, register address width (register 0 is hardwired zero)
- ALUW, 3, ALU op width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_op  in  OPW  opcode in ID
- id_rs, id_rt, id_rd  in  RAW  register fields in ID
- ex_zero  in  1  ALU zero flag for the instruction in EX
- stall  out  1  hold PC and IF/ID; bubble into ID/EX
- flush  out  1  discard IF/ID; bubble into ID/EX
- id_reg_dst  out  1  ID read-port-2 select: 1 = rt for SW/BEQ
- ex_aluop  out  ALUW  ALU operation
- ex_alu_src  out  1  1 = immediate operand
- fwd_a, fwd_b  out  2  operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
- mem_read, mem_write  out  1  data-memory strobes in MEM
- wb_write_en  out  1  regfile write in WB
- wb_mem_to_reg  out  1  1 = ALU result, 0 = load data
- wb_waddr  out  RAW  write address in WB

## Operation
- Decode:
  - Opcode 0xxx: ALU op = op[2:0], write rd.
  - LW (1000): add, alu_src, mem_read, write rd, mem_to_reg=0.
  - SW (1001): add, alu_src, mem_write, reg_dst.
  - BEQ (1010): sub, reg_dst, branch.
  - 1011–1111: reserved, decode as NOP (no write, no memory access).
- !id_valid decodes as NOP.
- Each stage register holds valid, the control bundle, rs, rt and waddr.
- Writes to register 0 are suppressed at decode (write_en=0).
- Load-use hazard: ID/EX holds a valid LW with waddr≠0 and waddr==id_rs. Also triggers on waddr==id_rt when the ID op reads rt (ALU, SW, BEQ).
  - stall=1; ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
- Branch: ID/EX holds a valid BEQ and ex_zero=1.
  - flush=1; ID/EX loads a bubble.
  - flush has priority over stall; stall is forced to 0 while flush=1.
- Forwarding for EX operand A (B identical, using rt):
  - 10 when EX/MEM is valid, write_en, not LW, waddr≠0 and waddr==ex_rs;
  - else 01 when MEM/WB is valid, write_en and waddr==ex_rs (≠0);
  - else 00.
  - EX/MEM wins over MEM/WB. A load in EX/MEM never forwards; the stall guarantees a one-slot gap.

## Timing
- Reset (async assert, sync release): all stage valid bits and every registered output are 0; stall = flush = 0; fwd_a = fwd_b = 00.
- Decode to ex_* controls: 1 cycle. To mem_*: 2 cycles. To wb_*: 3 cycles.
- stall, flush, fwd_a, fwd_b and id_reg_dst are combinational from current stage registers and ID inputs, with no added latency.
- One load-use stall lasts exactly 1 cycle. On the next cycle the LW has moved to EX/MEM and the condition clears.
- Branch penalty is 1 bubble (the ID instruction). IF-side discard is owned upstream via flush.
- Stall and flush in the same cycle: flush wins; the stalled ID instruction is discarded.
- Reset mid-operation clears in-flight instructions without issuing any memory or regfile strobe.

## Structure
- ctrl_pkg holds:
  - opcode constants (LW, SW, BEQ, reserved range);
  - ALU op constants (ADD, SUB, …);
  - FWD_RF / FWD_EXMEM / FWD_MEMWB encodings;
  - packed ctrl_t bundle type.
- Sub-module ctrl_decode: purely combinational opcode → ctrl_t. It is instantiated once in ID.
- Hazard, forwarding and stage registers live in pipe_ctrl.

## Test plan
- Reset: rst_n low mid-stream with LW in MEM → mem_read, wb_write_en, stall, flush all 0 immediately; a fresh ADD issued after release reaches wb_write_en=1 3 cycles later.
- Load-use: LW r3 then ADD r4,r3,r1 → stall=1 for exactly one cycle, ex_aluop bubble, then fwd_a=01 when the ADD is in EX.
- Back-to-back ALU: ADD r2 then SUB r5,r2,r2 → fwd_a=fwd_b=10, no stall. Instruction 2 later with r2 → fwd_a=01. Destination r0 → fwd_a=00.
- Branch: BEQ in EX with ex_zero=1 → flush=1 one cycle; the ID instruction never asserts wb_write_en. ex_zero=0 → no flush.
- Stall+flush: BEQ taken in EX while the ID instruction depends on… a LW cannot coexist in EX, so instead drive BEQ taken with a load-use pattern forced via ID inputs → flush=1, stall=0.
- Reserved opcode 1101 and id_valid=0 → no mem strobe, wb_write_en=0 3 cycles later.
